noc_inject_pkt_arbiter: RTL and testbench

- Merges NUM_SRC local source flit FIFOs into the single injection FIFO that the router bridge drains (its read-buffer side).
- Arbitrates round-robin at packet granularity: once a source is granted, it owns the output until its TAIL or HEADTAIL flit has been forwarded.
- Source FIFOs have 1-cycle read latency: data is valid the cycle after ren.
- Output is the write port of the destination FIFO, flow-controlled by afull/full.

---
 rtl/noc_inject_pkt_arbiter_if.sv | 34 +++
 rtl/noc_inject_pkt_arbiter.sv | 168 ++++++++++++++++
 tb/tb_noc_inject_pkt_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_inject_pkt_arbiter_if.sv
// Bundle between the injection arbiter (master side) and its source FIFOs,
// destination FIFO and status observers (slave side).
interface noc_inject_pkt_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int FLIT_W  = 34
);
  localparam int ID_W = $clog2(NUM_SRC);

  // Handshake: a source is read when src_ren[i] is high on a clk edge and
  // src_rempty[i] was low; its flit appears on src_rdata one cycle later.
  // A flit is accepted by the destination on every edge with dst_wen high;
  // dst_afull/dst_full stall new reads but never an in-flight write.
  logic [NUM_SRC-1:0]        src_en;
  logic [NUM_SRC-1:0]        src_rempty;
  logic [NUM_SRC-1:0]        src_ren;
  logic [NUM_SRC*FLIT_W-1:0] src_rdata;
  logic                      dst_afull;
  logic                      dst_full;
  logic                      dst_wen;
  logic [FLIT_W-1:0]         dst_wdata;
  logic                      grant_vld;
  logic [ID_W-1:0]           grant_id;
  logic                      timeout_err;

  modport master (
    input  src_en, src_rempty, src_rdata, dst_afull, dst_full,
    output src_ren, dst_wen, dst_wdata, grant_vld, grant_id, timeout_err
  );

  modport slave (
    output src_en, src_rempty, src_rdata, dst_afull, dst_full,
    input  src_ren, dst_wen, dst_wdata, grant_vld, grant_id, timeout_err
  );
endinterface

// File: rtl/noc_inject_pkt_arbiter.sv
// Packet-granular round-robin merge of NUM_SRC source flit FIFOs into one
// injection FIFO. Define NOC_INJ_ARB_TIMEOUT_EN to build the starvation timeout.
module noc_inject_pkt_arbiter #(
  parameter int         NUM_SRC      = 4,
  parameter int         FLIT_W       = 34,
  parameter logic [1:0] LBL_HEAD     = 2'd0,
  parameter logic [1:0] LBL_BODY     = 2'd1,
  parameter logic [1:0] LBL_TAIL     = 2'd2,
  parameter logic [1:0] LBL_HEADTAIL = 2'd3,
  parameter int         TIMEOUT_CYC  = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  noc_inject_pkt_arbiter_if.master    bus,
  output logic                        dbg_state_o
);

  localparam int ID_W = $clog2(NUM_SRC);

  if (NUM_SRC < 2 || NUM_SRC > 16 || TIMEOUT_CYC < 2 ||
      LBL_HEAD == LBL_BODY || LBL_HEAD == LBL_TAIL || LBL_HEAD == LBL_HEADTAIL ||
      LBL_BODY == LBL_TAIL || LBL_BODY == LBL_HEADTAIL || LBL_TAIL == LBL_HEADTAIL) begin : g_bad_cfg
    $error("noc_inject_pkt_arbiter: illegal parameter set");
  end

  typedef enum logic {IDLE = 1'b0, PKT = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                rd_vld_q;

  logic [NUM_SRC-1:0]  cand;
  logic [NUM_SRC-1:0]  ren;
  logic                hi_vld, lo_vld, pick_vld;
  logic [ID_W-1:0]     hi_id, lo_id, pick_id;
  logic [FLIT_W-1:0]   owner_flit;
  logic                owner_empty;
  logic [1:0]          ret_lbl;
  logic                last_lbl;
  logic                pkt_done;
  logic                rd_go;
  logic                tmo_fire;

  assign cand = bus.src_en & ~bus.src_rempty;

  // Sources above rr_ptr win over those at or below it; lowest index first in each half.
  always_comb begin
    hi_vld = 1'b0;
    hi_id  = '0;
    lo_vld = 1'b0;
    lo_id  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i] && (ID_W'(i) > rr_ptr_q)) begin
        hi_vld = 1'b1;
        hi_id  = ID_W'(i);
      end
      if (cand[i] && (ID_W'(i) <= rr_ptr_q)) begin
        lo_vld = 1'b1;
        lo_id  = ID_W'(i);
      end
    end
    pick_vld = hi_vld | lo_vld;
    pick_id  = hi_vld ? hi_id : lo_id;
  end

  always_comb begin
    owner_flit  = '0;
    owner_empty = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_id_q == ID_W'(i)) begin
        owner_flit  = bus.src_rdata[i*FLIT_W +: FLIT_W];
        owner_empty = bus.src_rempty[i];
      end
    end
  end

  assign ret_lbl  = owner_flit[FLIT_W-1 -: 2];
  assign last_lbl = (ret_lbl == LBL_TAIL) || (ret_lbl == LBL_HEADTAIL);
  assign pkt_done = rd_vld_q && last_lbl;
  // The returning flit's label gates the next read, so a packet never over-reads its tail.
  assign rd_go    = (state_q == PKT) && !owner_empty && !bus.dst_afull &&
                    !bus.dst_full && !pkt_done;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      ren[i] = rd_go && (grant_id_q == ID_W'(i));
    end
  end

`ifdef NOC_INJ_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_err_q;
  logic             starving;

  assign starving = (state_q == PKT) && owner_empty && !rd_vld_q;
  assign tmo_fire = starving && (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q != PKT || rd_go || tmo_fire) begin
      tmo_cnt_d = '0;
    end else if (starving) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_q | tmo_fire;
    end
  end

  assign bus.timeout_err = tmo_err_q;
`else
  assign tmo_fire        = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d    = PKT;
          grant_id_d = pick_id;
        end
      end
      PKT: begin
        if (pkt_done || tmo_fire) begin
          state_d  = IDLE;
          rr_ptr_d = grant_id_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      rr_ptr_q   <= ID_W'(NUM_SRC - 1);
      rd_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
      rd_vld_q   <= rd_go;
    end
  end

  assign bus.src_ren   = ren;
  assign bus.dst_wen   = rd_vld_q;
  assign bus.dst_wdata = rd_vld_q ? owner_flit : '0;
  assign bus.grant_vld = (state_q == PKT);
  assign bus.grant_id  = grant_id_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_noc_inject_pkt_arbiter.sv
// Directed bench for noc_inject_pkt_arbiter: modelled source FIFOs with
// one-cycle read latency, a write scoreboard and per-step immediate assertions.
module tb_noc_inject_pkt_arbiter;
  localparam int NUM_SRC = 4;
  localparam int FLIT_W  = 34;
`ifdef NOC_INJ_ARB_TIMEOUT_EN
  localparam int TIMEOUT_CYC = 16;
`else
  localparam int TIMEOUT_CYC = 1024;
`endif
  localparam logic [1:0] H = 2'd0, B = 2'd1, T = 2'd2, HT = 2'd3;

  logic clk = 1'b0;
  logic rst;
  logic dbg_state;

  int n_assert = 0;
  int n_fail   = 0;
  int n_wr     = 0;
  int wr_base;

  logic [FLIT_W-1:0] exp_q[$];
  logic [FLIT_W-1:0] mem[NUM_SRC][16];
  logic [3:0]        wr_ptr[NUM_SRC];
  logic [3:0]        rd_ptr[NUM_SRC];
  logic [FLIT_W-1:0] rdata_r[NUM_SRC];

  noc_inject_pkt_arbiter_if #(.NUM_SRC(NUM_SRC), .FLIT_W(FLIT_W)) bus ();

  noc_inject_pkt_arbiter #(
    .NUM_SRC    (NUM_SRC),
    .FLIT_W     (FLIT_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- source FIFO models ----------------
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign bus.src_rempty[i] = (rd_ptr[i] == wr_ptr[i]);
    assign bus.src_rdata[i*FLIT_W +: FLIT_W] = rdata_r[i];
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        rd_ptr[i]  <= '0;
        rdata_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (bus.src_ren[i]) begin
          rdata_r[i] <= mem[i][rd_ptr[i]];
          rd_ptr[i]  <= rd_ptr[i] + 4'd1;
        end
      end
    end
  end

  // ---------------- checker / scoreboard ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("ren_onehot0", 64'($onehot0(bus.src_ren)), 64'd1);
      chk("ren_on_empty", 64'(|(bus.src_ren & bus.src_rempty)), 64'd0);
      if (bus.dst_wen) begin
        n_wr++;
        chk("sb_write_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) chk("sb_data", 64'(bus.dst_wdata), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int s, input logic [1:0] lbl, input logic [31:0] d);
    mem[s][wr_ptr[s]] = {lbl, d};
    wr_ptr[s] = wr_ptr[s] + 4'd1;
  endtask

  task automatic expect_flit(input logic [1:0] lbl, input logic [31:0] d);
    exp_q.push_back({lbl, d});
  endtask

  task automatic do_reset;
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    rst = 1'b1;
    bus.src_en    = '1;
    bus.dst_afull = 1'b0;
    bus.dst_full  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) wr_ptr[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst           = 1'b1;
    bus.src_en    = '1;
    bus.dst_afull = 1'b0;
    bus.dst_full  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) wr_ptr[i] = '0;
    do_reset;

    // Reset state
    chk("rst_src_ren",     64'(bus.src_ren),     64'd0);
    chk("rst_dst_wen",     64'(bus.dst_wen),     64'd0);
    chk("rst_dst_wdata",   64'(bus.dst_wdata),   64'd0);
    chk("rst_grant_vld",   64'(bus.grant_vld),   64'd0);
    chk("rst_grant_id",    64'(bus.grant_id),    64'd0);
    chk("rst_timeout_err", 64'(bus.timeout_err), 64'd0);
    chk("rst_state",       64'(dbg_state),       64'd0);

    // Single 4-flit packet from src0
    wr_base = n_wr;
    push(0, H, 32'h100); push(0, B, 32'h101); push(0, B, 32'h102); push(0, T, 32'h103);
    expect_flit(H, 32'h100); expect_flit(B, 32'h101); expect_flit(B, 32'h102); expect_flit(T, 32'h103);
    #1;
    chk("t1_idle_no_ren", 64'(bus.src_ren), 64'd0);
    tick;
    chk("t1_grant_vld", 64'(bus.grant_vld), 64'd1);
    chk("t1_grant_id",  64'(bus.grant_id),  64'd0);
    chk("t1_state_pkt", 64'(dbg_state),     64'd1);
    chk("t1_first_ren", 64'(bus.src_ren),   64'b0001);
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("t1_wen", 64'(bus.dst_wen), 64'd1);
      chk("t1_label", 64'(bus.dst_wdata[FLIT_W-1 -: 2]), (k == 0) ? 64'(H) : (k == 3) ? 64'(T) : 64'(B));
    end
    chk("t1_grant_on_tail", 64'(bus.grant_vld), 64'd1);
    chk("t1_no_ren_on_tail", 64'(bus.src_ren), 64'd0);
    tick;
    chk("t1_grant_dropped", 64'(bus.grant_vld), 64'd0);
    chk("t1_wen_low", 64'(bus.dst_wen), 64'd0);
    chk("t1_write_count", 64'(n_wr - wr_base), 64'd4);

    // Round robin between src0 and src2 single-flit packets
    do_reset;
    push(0, HT, 32'h200); push(0, HT, 32'h201);
    push(2, HT, 32'h220); push(2, HT, 32'h221);
    expect_flit(HT, 32'h200); expect_flit(HT, 32'h220);
    expect_flit(HT, 32'h201); expect_flit(HT, 32'h221);
    for (int p = 0; p < 4; p++) begin
      tick;
      chk("t2_grant_vld", 64'(bus.grant_vld), 64'd1);
      chk("t2_grant_id",  64'(bus.grant_id),  (p % 2 == 0) ? 64'd0 : 64'd2);
      tick;
      chk("t2_wen", 64'(bus.dst_wen), 64'd1);
      tick;
      chk("t2_idle_gap_grant", 64'(bus.grant_vld), 64'd0);
      chk("t2_idle_gap_wen",   64'(bus.dst_wen),   64'd0);
    end

    // src1 6-flit stream with afull for 5 cycles from the flit-3 return
    do_reset;
    wr_base = n_wr;
    push(1, H, 32'h300);
    for (int k = 1; k < 5; k++) push(1, B, 32'h300 + 32'(k));
    push(1, T, 32'h305);
    expect_flit(H, 32'h300);
    for (int k = 1; k < 5; k++) expect_flit(B, 32'h300 + 32'(k));
    expect_flit(T, 32'h305);
    tick;
    chk("t3_grant_id", 64'(bus.grant_id), 64'd1);
    tick;
    tick;
    tick;
    bus.dst_afull = 1'b1;
    #1;
    chk("t3_inflight_written", 64'(bus.dst_wen), 64'd1);
    chk("t3_no_ren_afull",     64'(bus.src_ren), 64'd0);
    repeat (4) begin
      tick;
      chk("t3_stalled_wen", 64'(bus.dst_wen), 64'd0);
      chk("t3_stalled_ren", 64'(bus.src_ren), 64'd0);
    end
    tick;
    bus.dst_afull = 1'b0;
    #1;
    chk("t3_resume_ren", 64'(bus.src_ren), 64'b0010);
    repeat (4) tick;
    chk("t3_write_count", 64'(n_wr - wr_base), 64'd6);
    chk("t3_grant_dropped", 64'(bus.grant_vld), 64'd0);

    // Owner src1 runs dry mid-packet while src3 waits
    do_reset;
    push(1, H, 32'h400); push(1, B, 32'h401);
    push(3, HT, 32'h4f0);
    expect_flit(H, 32'h400); expect_flit(B, 32'h401);
    expect_flit(T, 32'h402); expect_flit(HT, 32'h4f0);
    tick;
    chk("t4_grant_id", 64'(bus.grant_id), 64'd1);
    tick;
    tick;
    repeat (10) begin
      tick;
      chk("t4_hold_no_ren", 64'(bus.src_ren),   64'd0);
      chk("t4_hold_owner",  64'(bus.grant_id),  64'd1);
      chk("t4_hold_vld",    64'(bus.grant_vld), 64'd1);
    end
    push(1, T, 32'h402);
    #1;
    chk("t4_tail_ren", 64'(bus.src_ren), 64'b0010);
    tick;
    chk("t4_tail_wen", 64'(bus.dst_wen), 64'd1);
    tick;
    chk("t4_idle", 64'(bus.grant_vld), 64'd0);
    tick;
    chk("t4_next_owner", 64'(bus.grant_id), 64'd3);
    tick;
    chk("t4_src3_wen", 64'(bus.dst_wen), 64'd1);
    tick;

    // Masked source, then enabled; dst_full stalls the first read
    do_reset;
    bus.src_en = 4'b1011;
    push(2, HT, 32'h500);
    expect_flit(HT, 32'h500);
    repeat (3) begin
      tick;
      chk("t5_masked_no_grant", 64'(bus.grant_vld), 64'd0);
    end
    bus.src_en = 4'b1111;
    tick;
    chk("t5_grant_vld", 64'(bus.grant_vld), 64'd1);
    chk("t5_grant_id",  64'(bus.grant_id),  64'd2);
    bus.dst_full = 1'b1;
    #1;
    chk("t5_full_no_ren", 64'(bus.src_ren), 64'd0);
    tick;
    chk("t5_full_no_wen", 64'(bus.dst_wen), 64'd0);
    bus.dst_full = 1'b0;
    #1;
    chk("t5_ren_after_full", 64'(bus.src_ren), 64'b0100);
    tick;
    chk("t5_wen", 64'(bus.dst_wen), 64'd1);
    tick;
    chk("t5_idle", 64'(bus.grant_vld), 64'd0);

`ifdef NOC_INJ_ARB_TIMEOUT_EN
    // Owner starves after its HEAD
    do_reset;
    push(0, H, 32'h600);
    push(1, HT, 32'h610);
    expect_flit(H, 32'h600); expect_flit(HT, 32'h610);
    tick;
    chk("t6_grant_id", 64'(bus.grant_id), 64'd0);
    tick;
    repeat (16) tick;
    chk("t6_err_before", 64'(bus.timeout_err), 64'd0);
    chk("t6_vld_before", 64'(bus.grant_vld),   64'd1);
    tick;
    chk("t6_err_set",      64'(bus.timeout_err), 64'd1);
    chk("t6_grant_dropped", 64'(bus.grant_vld),  64'd0);
    tick;
    chk("t6_next_owner", 64'(bus.grant_id), 64'd1);
    tick;
    tick;
    tick;
    chk("t6_err_sticky", 64'(bus.timeout_err), 64'd1);
    do_reset;
    chk("t6_err_cleared", 64'(bus.timeout_err), 64'd0);
`endif

    do_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
